// File: rtl/uart_tx_buf_if.sv
// Upstream valid/ready word channel feeding the uart_tx_buf input FIFO.
interface uart_tx_buf_if #(
  parameter int MAX_DATA_W = 9
);
  logic                  s_valid;
  logic                  s_ready;
  logic [MAX_DATA_W-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: input FIFO, programmable baud divider and
// per-frame latched configuration (length, parity, stop bits).
module uart_tx_buf #(
  parameter int MAX_DATA_W = 9,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                          tx_clk,
  input  logic                          rst,
  uart_tx_buf_if.slave                  s,
  input  logic [3:0]                    cfg_len,
  input  logic                          cfg_parity_en,
  input  logic [1:0]                    cfg_parity_mode,
  input  logic                          cfg_stop2,
  input  logic [DIV_W-1:0]              cfg_div,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic                          tx_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [3:0] LEN_MAX = 4'(MAX_DATA_W);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } state_t;

  function automatic logic [MAX_DATA_W-1:0] mask_word(
    input logic [MAX_DATA_W-1:0] word,
    input logic [3:0]            len
  );
    logic [MAX_DATA_W-1:0] m;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      m[i] = word[i] & (i < int'(len));
    end
    return m;
  endfunction

  function automatic logic frame_parity(
    input logic [MAX_DATA_W-1:0] bits,
    input logic [1:0]            mode
  );
    logic p;
    case (mode)
      2'b00:   p = ^bits;
      2'b01:   p = ~^bits;
      2'b10:   p = 1'b1;
      2'b11:   p = 1'b0;
      default: p = 1'b0;
    endcase
    return p;
  endfunction

  logic [MAX_DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [LW-1:0]         level_r;
  logic [LW-1:0]         level_nxt_s;
  logic                  ready_r;
  logic                  push_s;
  logic                  pop_s;
  logic [MAX_DATA_W-1:0] head_s;
  logic [MAX_DATA_W-1:0] head_masked_s;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [DIV_W-1:0]      cnt_r;
  logic [DIV_W-1:0]      div_r;
  logic [DIV_W-1:0]      cfg_div_eff_s;
  logic [3:0]            bit_r;
  logic [3:0]            len_r;
  logic [MAX_DATA_W-1:0] shift_r;
  logic                  par_en_r;
  logic                  par_bit_r;
  logic                  stop2_r;

  logic                  tick_s;
  logic                  last_bit_s;
  logic                  eof_s;
  logic                  len_ok_s;
  logic                  start_ok_s;

  logic                  tx_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  err_r;
  logic                  tx_nxt_s;
  logic                  busy_nxt_s;
  logic                  done_nxt_s;
  logic                  err_nxt_s;

  assign push_s        = s.s_valid & ready_r;
  assign head_s        = mem_r[rd_ptr_r];
  assign head_masked_s = mask_word(head_s, cfg_len);
  assign cfg_div_eff_s = (cfg_div == {DIV_W{1'b0}}) ? DIV_W'(1) : cfg_div;
  assign len_ok_s      = (cfg_len >= 4'd5) && (cfg_len <= LEN_MAX);
  assign tick_s        = (cnt_r == {DIV_W{1'b0}});
  assign last_bit_s    = (bit_r == (len_r - 4'd1));
  assign eof_s         = tick_s && (((state_r == ST_STOP1) && !stop2_r) || (state_r == ST_STOP2));
  assign pop_s         = (level_r != {LW{1'b0}}) && ((state_r == ST_IDLE) || eof_s);
  assign start_ok_s    = pop_s && len_ok_s;

  assign s.s_ready  = ready_r;
  assign fifo_level = level_r;
  assign tx         = tx_r;
  assign busy       = busy_r;
  assign tx_done    = done_r;
  assign tx_err     = err_r;

  // FIFO occupancy after this cycle's push/pop.
  always_comb begin
    level_nxt_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LW'(1);
      2'b01:   level_nxt_s = level_r - LW'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge tx_clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= s.s_data;
    end
  end

  // FIFO pointers, level and registered ready (low whenever level is full).
  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
      ready_r  <= 1'b1;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      level_r <= level_nxt_s;
      ready_r <= (level_nxt_s != LW'(FIFO_DEPTH));
    end
  end

  // FSM state register.
  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state; a frame end with a queued word chains straight into START.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:   state_nxt_s = start_ok_s ? ST_START : ST_IDLE;
      ST_START:  state_nxt_s = tick_s ? ST_DATA : ST_START;
      ST_DATA: begin
        if (tick_s && last_bit_s) begin
          state_nxt_s = par_en_r ? ST_PARITY : ST_STOP1;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      ST_PARITY: state_nxt_s = tick_s ? ST_STOP1 : ST_PARITY;
      ST_STOP1: begin
        if (!tick_s) begin
          state_nxt_s = ST_STOP1;
        end else if (stop2_r) begin
          state_nxt_s = ST_STOP2;
        end else begin
          state_nxt_s = start_ok_s ? ST_START : ST_IDLE;
        end
      end
      ST_STOP2: begin
        if (tick_s) begin
          state_nxt_s = start_ok_s ? ST_START : ST_IDLE;
        end else begin
          state_nxt_s = ST_STOP2;
        end
      end
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs, computed for the state being entered so tx is a plain flop.
  always_comb begin
    tx_nxt_s   = 1'b1;
    busy_nxt_s = (state_nxt_s != ST_IDLE);
    done_nxt_s = eof_s;
    err_nxt_s  = pop_s && !len_ok_s;
    case (state_nxt_s)
      ST_IDLE:   tx_nxt_s = 1'b1;
      ST_START:  tx_nxt_s = 1'b0;
      ST_DATA:   tx_nxt_s = ((state_r == ST_DATA) && tick_s) ? shift_r[1] : shift_r[0];
      ST_PARITY: tx_nxt_s = par_bit_r;
      ST_STOP1:  tx_nxt_s = 1'b1;
      ST_STOP2:  tx_nxt_s = 1'b1;
      default:   tx_nxt_s = 1'b1;
    endcase
  end

  // Registered serial line and status pulses.
  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      tx_r   <= 1'b1;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      tx_r   <= tx_nxt_s;
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
      err_r  <= err_nxt_s;
    end
  end

  // Per-frame datapath: config and word are captured at pop and held to frame end.
  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      cnt_r     <= {DIV_W{1'b0}};
      div_r     <= DIV_W'(1);
      bit_r     <= 4'd0;
      len_r     <= 4'd0;
      shift_r   <= {MAX_DATA_W{1'b0}};
      par_en_r  <= 1'b0;
      par_bit_r <= 1'b0;
      stop2_r   <= 1'b0;
    end else begin
      if (pop_s) begin
        cnt_r     <= cfg_div_eff_s - DIV_W'(1);
        div_r     <= cfg_div_eff_s;
        bit_r     <= 4'd0;
        len_r     <= cfg_len;
        shift_r   <= head_masked_s;
        par_en_r  <= cfg_parity_en;
        par_bit_r <= frame_parity(head_masked_s, cfg_parity_mode);
        stop2_r   <= cfg_stop2;
      end else if (tick_s) begin
        cnt_r <= div_r - DIV_W'(1);
        if (state_r == ST_DATA) begin
          bit_r   <= bit_r + 4'd1;
          shift_r <= shift_r >> 1;
        end
      end else begin
        cnt_r <= cnt_r - DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Scoreboard bench for uart_tx_buf: stimulus queues expected serial frames,
// a negedge monitor decodes tx and compares against the queue.
module tb_uart_tx_buf;
  localparam int MAX_DATA_W = 9;
  localparam int FIFO_DEPTH = 8;
  localparam int DIV_W      = 16;

  typedef struct {
    logic [15:0] bits;       // first transmitted bit is bits[nbits-1]
    int          nbits;
    int          div;        // effective cycles per bit
    int          start_cyc;  // -1 when not checked
    int          busy_after; // 0/1, or 2 when not checked
  } frame_t;

  logic        tx_clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  cfg_len;
  logic        cfg_parity_en;
  logic [1:0]  cfg_parity_mode;
  logic        cfg_stop2;
  logic [15:0] cfg_div;
  logic        tx, busy, tx_done, tx_err;
  logic [3:0]  fifo_level;

  uart_tx_buf_if #(.MAX_DATA_W(MAX_DATA_W)) s_if ();

  uart_tx_buf #(.MAX_DATA_W(MAX_DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
    .tx_clk(tx_clk), .rst(rst), .s(s_if),
    .cfg_len(cfg_len), .cfg_parity_en(cfg_parity_en), .cfg_parity_mode(cfg_parity_mode),
    .cfg_stop2(cfg_stop2), .cfg_div(cfg_div),
    .tx(tx), .busy(busy), .tx_done(tx_done), .tx_err(tx_err), .fifo_level(fifo_level)
  );

  always #5 tx_clk = ~tx_clk;

  int     cyc = 0;
  int     n_checks = 0;
  int     n_pass = 0;
  frame_t exp_q[$];
  frame_t cur;
  bit     mon_in_frame = 1'b0;
  bit     mon_done_chk = 1'b0;
  bit     mon_stray = 1'b0;
  int     mon_idx, mon_bad;
  logic [15:0] mon_cap;
  int     done_cnt = 0;
  int     err_cnt = 0;

  always @(posedge tx_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference frame builder: start, LSB-first data, optional parity, stop bit(s).
  function automatic logic [15:0] mk_frame(input logic [8:0] d, input int len, input bit pen,
                                           input logic [1:0] pm, input bit st2);
    logic [15:0] v;
    logic        p;
    v = 16'd0;
    p = 1'b0;
    for (int i = 0; i < len; i++) begin
      v = {v[14:0], d[i]};
      p = p ^ d[i];
    end
    if (pen) begin
      case (pm)
        2'b00:   v = {v[14:0], p};
        2'b01:   v = {v[14:0], ~p};
        2'b10:   v = {v[14:0], 1'b1};
        default: v = {v[14:0], 1'b0};
      endcase
    end
    v = {v[14:0], 1'b1};
    if (st2) v = {v[14:0], 1'b1};
    return v;
  endfunction

  task automatic enqueue(input logic [15:0] bits, input int nbits, input int div,
                         input int start_cyc, input int busy_after);
    frame_t f;
    f.bits = bits; f.nbits = nbits; f.div = div;
    f.start_cyc = start_cyc; f.busy_after = busy_after;
    exp_q.push_back(f);
  endtask

  // One-cycle push; nbits==0 means the word is expected to be dropped.
  task automatic push_word(input logic [8:0] d, input logic [15:0] bits, input int nbits,
                           input int div, input int start_rel, input int busy_after);
    logic rdy;
    @(negedge tx_clk);
    s_if.s_valid = 1'b1;
    s_if.s_data  = d;
    rdy = s_if.s_ready;
    check("s_ready_at_push", rdy, 1);
    @(posedge tx_clk);
    #1;
    s_if.s_valid = 1'b0;
    if (nbits > 0) enqueue(bits, nbits, div, (start_rel >= 0) ? cyc + start_rel : -1, busy_after);
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_in_frame || mon_done_chk || busy || fifo_level != 4'd0)
           && n < max_cyc) begin
      @(negedge tx_clk);
      n++;
    end
    check("drain_within_budget", (n < max_cyc), 1);
  endtask

  // Monitor: decode tx against the expected-frame queue.
  initial begin
    logic expbit;
    forever begin
      @(negedge tx_clk);
      if (tx_done) done_cnt++;
      if (tx_err)  err_cnt++;
      if (rst) begin
        mon_in_frame = 1'b0;
        mon_done_chk = 1'b0;
      end else begin
        if (mon_done_chk) begin
          check("tx_done_at_frame_end", tx_done, 1);
          if (cur.busy_after != 2) check("busy_after_frame", busy, cur.busy_after);
          mon_done_chk = 1'b0;
        end
        if (tx === 1'b1) mon_stray = 1'b0;
        if (!mon_in_frame && tx === 1'b0) begin
          if (exp_q.size() == 0) begin
            if (!mon_stray) check("tx_idle_without_word", tx, 1);
            mon_stray = 1'b1;
          end else begin
            cur = exp_q.pop_front();
            mon_in_frame = 1'b1;
            mon_idx = 0;
            mon_bad = 0;
            mon_cap = 16'd0;
            if (cur.start_cyc >= 0) check("frame_start_cycle", cyc, cur.start_cyc);
          end
        end
        if (mon_in_frame) begin
          expbit = cur.bits[cur.nbits - 1 - mon_idx / cur.div];
          if (mon_idx % cur.div == 0) mon_cap[cur.nbits - 1 - mon_idx / cur.div] = tx;
          if (tx !== expbit) mon_bad++;
          mon_idx++;
          if (mon_idx == cur.nbits * cur.div) begin
            check("frame_bits", mon_cap, cur.bits);
            check("frame_bit_hold_errors", mon_bad, 0);
            mon_in_frame = 1'b0;
            mon_done_chk = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int   k, n, n0;
    logic rdy, prev_rdy, low_seen;
    s_if.s_valid = 1'b0;
    s_if.s_data  = 9'd0;
    cfg_len = 4'd8; cfg_parity_en = 1'b0; cfg_parity_mode = 2'b00;
    cfg_stop2 = 1'b0; cfg_div = 16'd4;
    repeat (3) @(negedge tx_clk);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_tx_done", tx_done, 0);
    check("reset_tx_err", tx_err, 0);
    check("reset_fifo_level", fifo_level, 0);
    check("reset_s_ready", s_if.s_ready, 1);
    rst = 1'b0;
    @(negedge tx_clk);

    // 8E1, div 4, 0xA5
    cfg_div = 16'd4; cfg_len = 4'd8; cfg_parity_en = 1'b1; cfg_parity_mode = 2'b00; cfg_stop2 = 1'b0;
    push_word(9'h0A5, 16'b01010010101, 11, 4, 1, 0);
    wait_idle(200);

    // 5O2, div 1, upper bits ignored
    cfg_div = 16'd1; cfg_len = 4'd5; cfg_parity_mode = 2'b01; cfg_stop2 = 1'b1;
    push_word(9'h1F5, 16'b010101011, 9, 1, 1, 0);
    wait_idle(100);

    // back-to-back 8N1, div 0
    cfg_div = 16'd0; cfg_len = 4'd8; cfg_parity_en = 1'b0; cfg_stop2 = 1'b0;
    push_word(9'h000, 16'b0000000001, 10, 1, 1, 1);
    push_word(9'h0FF, 16'b0111111111, 10, 1, 10, 0);
    wait_idle(100);

    // FIFO full, 5N1, div 100
    cfg_div = 16'd100; cfg_len = 4'd5;
    k = 0;
    s_if.s_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      s_if.s_data = 9'(k);
      rdy = s_if.s_ready;
      @(posedge tx_clk);
      #1;
      if (rdy) begin
        enqueue(mk_frame(9'(k), 5, 1'b0, 2'b00, 1'b0), 7, 100, (k == 0) ? cyc + 1 : -1, 2);
        k++;
      end
      @(negedge tx_clk);
    end
    s_if.s_valid = 1'b0;
    check("full_words_accepted", k, 9);
    check("full_fifo_level", fifo_level, 8);
    check("full_s_ready_low", s_if.s_ready, 0);
    n = 0;
    prev_rdy = s_if.s_ready;
    while (!tx_done && n < 2000) begin
      prev_rdy = s_if.s_ready;
      @(negedge tx_clk);
      n++;
    end
    check("full_frame0_done_seen", tx_done, 1);
    check("full_s_ready_low_before_end", prev_rdy, 0);
    check("full_s_ready_after_end", s_if.s_ready, 1);
    check("full_level_after_end", fifo_level, 7);
    wait_idle(8000);

    // illegal length followed by a legal word
    cfg_div = 16'd2; cfg_len = 4'd4;
    push_word(9'h011, 16'd0, 0, 2, -1, 2);
    @(posedge tx_clk);
    @(negedge tx_clk);
    check("illegal_tx_err_pulse", tx_err, 1);
    check("illegal_tx_high", tx, 1);
    check("illegal_not_busy", busy, 0);
    cfg_len = 4'd8;
    push_word(9'h03C, 16'b0001111001, 10, 2, 1, 0);
    wait_idle(100);

    // reset during data bit 3 with three words queued
    cfg_div = 16'd4;
    push_word(9'h011, mk_frame(9'h011, 8, 1'b0, 2'b00, 1'b0), 10, 4, 1, 2);
    n0 = cyc;
    push_word(9'h022, mk_frame(9'h022, 8, 1'b0, 2'b00, 1'b0), 10, 4, -1, 2);
    push_word(9'h033, mk_frame(9'h033, 8, 1'b0, 2'b00, 1'b0), 10, 4, -1, 2);
    push_word(9'h044, mk_frame(9'h044, 8, 1'b0, 2'b00, 1'b0), 10, 4, -1, 2);
    check("pre_reset_level", fifo_level, 3);
    while (cyc < n0 + 18) begin
      @(posedge tx_clk);
      #1;
    end
    #1;
    rst = 1'b1;
    #1;
    check("midframe_reset_tx", tx, 1);
    check("midframe_reset_busy", busy, 0);
    check("midframe_reset_level", fifo_level, 0);
    check("midframe_reset_s_ready", s_if.s_ready, 1);
    exp_q.delete();
    repeat (2) @(posedge tx_clk);
    #2;
    rst = 1'b0;
    low_seen = 1'b0;
    repeat (100) begin
      @(negedge tx_clk);
      if (tx !== 1'b1 || busy !== 1'b0) low_seen = 1'b1;
    end
    check("post_reset_quiet", low_seen, 0);
    check("post_reset_level", fifo_level, 0);

    // recovery after reset: 8N1, div 1, 0x5A
    cfg_div = 16'd1;
    push_word(9'h05A, 16'b0010110101, 10, 1, 1, 0);
    wait_idle(100);

    check("total_tx_done_pulses", done_cnt, 15);
    check("total_tx_err_pulses", err_cnt, 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
